// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, constant latency for every op.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mq_r;
  logic [WIDTH-1:0] mcand_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             bz_r;
  logic             done_r;
  logic             dz_r;
  logic [WIDTH-1:0] result_r;

  logic             a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   mul_sum_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_sub_s;
  logic [WIDTH-1:0] acc_nx_s, mq_nx_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0] quo_s, rem_s, fix_s;

  // Operand signedness by op; MUL is treated as signed since its low half is sign-agnostic.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b1;
      end
      3'b010: begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b0;
      end
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
    a_neg_s = a_sgn_s & a[WIDTH-1];
    b_neg_s = b_sgn_s & b[WIDTH-1];
    if (a_neg_s) a_mag_s = -a;
    else         a_mag_s = a;
    if (b_neg_s) b_mag_s = -b;
    else         b_mag_s = b;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s = {1'b0, acc_r} + ({(WIDTH+1){mq_r[0]}} & {1'b0, mcand_r});
    div_ge_s  = ({acc_r, mq_r[WIDTH-1]} >= {1'b0, mcand_r});
    div_sub_s = {acc_r[WIDTH-2:0], mq_r[WIDTH-1]} - mcand_r;
    if (op_r[2]) begin
      mq_nx_s = {mq_r[WIDTH-2:0], div_ge_s};
      if (div_ge_s) acc_nx_s = div_sub_s;
      else          acc_nx_s = {acc_r[WIDTH-2:0], mq_r[WIDTH-1]};
    end else begin
      acc_nx_s = mul_sum_s[WIDTH:1];
      mq_nx_s  = {mul_sum_s[0], mq_r[WIDTH-1:1]};
    end
  end

  // Sign correction and result selection; divide-by-zero overrides the datapath.
  always_comb begin
    prod_s = {acc_r, mq_r};
    if (neg_q_r) begin
      prod_fix_s = -prod_s;
      quo_s      = -mq_r;
    end else begin
      prod_fix_s = prod_s;
      quo_s      = mq_r;
    end
    if (neg_r_r) rem_s = -acc_r;
    else         rem_s = acc_r;
    case (op_r)
      3'b000:                 fix_s = prod_fix_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_s = bz_r ? {WIDTH{1'b1}} : quo_s;
      3'b110, 3'b111:         fix_s = bz_r ? a_r : rem_s;
      default:                fix_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic: IDLE -> CALC for WIDTH cycles -> FIX -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CALC;
        else       state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == {CW{1'b0}}) state_s = FIX;
        else                     state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Operand capture, iteration datapath and registered result/flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r     <= 3'b000;
      a_r      <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mq_r     <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      bz_r     <= 1'b0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      done_r <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            a_r     <= a;
            acc_r   <= {WIDTH{1'b0}};
            mq_r    <= a_mag_s;
            mcand_r <= b_mag_s;
            cnt_r   <= CW'(WIDTH - 1);
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            bz_r    <= (b == {WIDTH{1'b0}});
          end
        end
        CALC: begin
          acc_r <= acc_nx_s;
          mq_r  <= mq_nx_s;
          cnt_r <= cnt_r - CW'(1);
        end
        FIX: begin
          result_r <= fix_s;
          dz_r     <= op_r[2] & bz_r;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = (state_r != IDLE);
  assign done   = done_r;
  assign result = result_r;
  assign dz     = dz_r;
  assign z      = (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: a 32-bit and an 8-bit instance, directed
// corner cases plus random ops checked against a wide-integer reference model.
module tb_mdu_iter;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, busy32, done32, z32, dz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        start8, busy8, done8, z8, dz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;

  mdu_iter #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .z(z32), .dz(dz32)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .z(z8), .dz(dz8)
  );

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q32[$];
  exp_t q8[$];
  int   done_cnt32 = 0;
  logic rst_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rst_prev <= rst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %s, expected none", name, what);
  endtask

  // Reference: exact wide-integer arithmetic on w-bit operands.
  function automatic logic [63:0] ref_mdu(input int w, input logic [2:0] o,
                                          input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] one, m, ux, uy, sx, sy, r;
    one = 128'sd1;
    m   = (one <<< w) - one;
    ux  = $signed({64'd0, x}) & m;
    uy  = $signed({64'd0, y}) & m;
    sx  = x[w-1] ? ux - (one <<< w) : ux;
    sy  = y[w-1] ? uy - (one <<< w) : uy;
    case (o)
      3'b000:  r = sx * sy;
      3'b001:  r = (sx * sy) >>> w;
      3'b010:  r = (sx * uy) >>> w;
      3'b011:  r = (ux * uy) >>> w;
      3'b100:  r = (sy == '0) ? m : sx / sy;
      3'b101:  r = (uy == '0) ? m : ux / uy;
      3'b110:  r = (sy == '0) ? sx : sx % sy;
      default: r = (uy == '0) ? ux : ux % uy;
    endcase
    r = r & m;
    return r[63:0];
  endfunction

  // Monitor for the 32-bit instance.
  logic        done_prev32 = 1'b0;
  logic [31:0] prev_res32 = 32'd0;
  logic        prev_dz32 = 1'b0;
  int          busy_run32 = 0;
  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32 === 1'b1) begin
      done_cnt32 <= done_cnt32 + 1;
      check("done32_pulse", done_prev32, 0);
      check("busy32_at_done", busy32, 0);
      check("busy32_len", busy_run32, 33);
      if (q32.size() == 0) fail("done32_unexpected", "done");
      else begin
        e = q32.pop_front();
        check("res32", res32, e.res);
        check("dz32", dz32, e.dz);
        check("z32", z32, e.res == 64'd0);
        check("lat32", cyc - e.cyc, 34);
      end
    end else if (!rst && !rst_prev) begin
      check("res32_hold", res32, prev_res32);
      check("dz32_hold", dz32, prev_dz32);
    end
    done_prev32 <= done32;
    prev_res32  <= res32;
    prev_dz32   <= dz32;
    busy_run32  <= busy32 ? busy_run32 + 1 : 0;
  end

  // Monitor for the 8-bit instance.
  logic       done_prev8 = 1'b0;
  logic [7:0] prev_res8 = 8'd0;
  logic       prev_dz8 = 1'b0;
  int         busy_run8 = 0;
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 === 1'b1) begin
      check("done8_pulse", done_prev8, 0);
      check("busy8_at_done", busy8, 0);
      check("busy8_len", busy_run8, 9);
      if (q8.size() == 0) fail("done8_unexpected", "done");
      else begin
        e = q8.pop_front();
        check("res8", res8, e.res);
        check("dz8", dz8, e.dz);
        check("z8", z8, e.res == 64'd0);
        check("lat8", cyc - e.cyc, 10);
      end
    end else if (!rst && !rst_prev) begin
      check("res8_hold", res8, prev_res8);
      check("dz8_hold", dz8, prev_dz8);
    end
    done_prev8 <= done8;
    prev_res8  <= res8;
    prev_dz8   <= dz8;
    busy_run8  <= busy8 ? busy_run8 + 1 : 0;
  end

  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] er, input logic ed, input bit push);
    int g;
    g = 0;
    @(negedge clk);
    while (busy32 !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail("issue32_timeout", "busy stuck");
    start32 = 1'b1;
    op32 = o;
    a32 = x;
    b32 = y;
    if (push) q32.push_back('{er, ed, cyc});
    @(posedge clk);
    #1 start32 = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [63:0] er, input logic ed);
    int g;
    g = 0;
    @(negedge clk);
    while (busy8 !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail("issue8_timeout", "busy stuck");
    start8 = 1'b1;
    op8 = o;
    a8 = x;
    b8 = y;
    q8.push_back('{er, ed, cyc});
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q32.size() != 0 || q8.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) fail("drain_timeout", "pending results");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [7:0]  x8, y8;
    int          dc;
    rst = 1'b1;
    start32 = 1'b0; op32 = 3'b000; a32 = 32'd0; b32 = 32'd0;
    start8 = 1'b0;  op8 = 3'b000;  a8 = 8'd0;   b8 = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    check("rst_result", res32, 0);
    check("rst_dz", dz32, 0);
    check("rst_z", z32, 1);

    // Directed 32-bit ops, issued back-to-back (each start lands in the previous done cycle).
    issue32(3'b000, 32'd7,          32'hFFFFFFFD, 64'hFFFFFFEB, 1'b0, 1'b1);
    issue32(3'b001, 32'h80000000,   32'h80000000, 64'h40000000, 1'b0, 1'b1);
    issue32(3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'hFFFFFFFE, 1'b0, 1'b1);
    issue32(3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b1);
    issue32(3'b100, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFD, 1'b0, 1'b1);
    issue32(3'b110, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF, 1'b0, 1'b1);
    issue32(3'b101, 32'd100,        32'd7,        64'd14,       1'b0, 1'b1);
    issue32(3'b111, 32'd100,        32'd7,        64'd2,        1'b0, 1'b1);
    issue32(3'b100, 32'd5,          32'd0,        64'hFFFFFFFF, 1'b1, 1'b1);
    issue32(3'b100, 32'h80000000,   32'hFFFFFFFF, 64'h80000000, 1'b0, 1'b1);
    issue32(3'b110, 32'h80000000,   32'hFFFFFFFF, 64'd0,        1'b0, 1'b1);

    // Starts while busy must be ignored.
    issue32(3'b100, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      start32 = 1'b1;
      op32 = 3'b000;
      a32 = $urandom;
      b32 = $urandom;
      @(negedge clk);
    end
    start32 = 1'b0;
    issue32(3'b111, 32'd5, 32'd0, 64'd5, 1'b1, 1'b1);
    drain();

    // Reset at cycle 10 of an op, with a simultaneous start on both units.
    issue32(3'b000, 32'd12345, 32'd678, 64'd0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start32 = 1'b1;
    start8 = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start32 = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy32, 0);
    check("mid_rst_done", done32, 0);
    check("mid_rst_result", res32, 0);
    check("mid_rst_dz", dz32, 0);
    check("mid_rst_z", z32, 1);
    check("rst_start_drop", busy8, 0);
    dc = done_cnt32;
    repeat (45) @(negedge clk);
    check("aborted_no_done", done_cnt32, dc);

    // Directed 8-bit ops.
    issue8(3'b001, 8'h80, 8'h7F, 64'hC0, 1'b0);
    issue8(3'b100, 8'h81, 8'h03, 64'hD6, 1'b0);

    // Random 8-bit sweep with biased corner operands.
    for (int i = 0; i < 60; i++) begin
      o  = 3'($urandom_range(0, 7));
      x8 = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      case ($urandom_range(0, 7))
        0:       y8 = 8'h00;
        1:       y8 = 8'hFF;
        default: y8 = 8'($urandom);
      endcase
      issue8(o, x8, y8, ref_mdu(8, o, {56'd0, x8}, {56'd0, y8}), o[2] && (y8 == 8'd0));
    end
    drain();

    // Random 32-bit sweep with biased corner operands.
    for (int i = 0; i < 25; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'hFFFFFFFF;
        default: y = 32'($urandom);
      endcase
      issue32(o, x, y, ref_mdu(32, o, {32'd0, x}, {32'd0, y}), o[2] && (y == 32'd0), 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
